// File: rtl/dmem_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the memory port (slave).
// One outstanding request: req/gnt address phase, then a single rvalid response.
interface dmem_lsu_if;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );
endinterface

// File: rtl/dmem_lsu.sv
// Load/store unit: one core access at a time, byte/half/word lanes, alignment check,
// bus error and response timeout reporting.
//
// state | meaning
// IDLE  | waiting for i_req; operands latched on acceptance
// REQ   | bus request held until grant
// WAIT  | granted, waiting for rvalid
// DONE  | one-cycle completion pulse with result flags
module dmem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hBABECAFE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_misaligned,
  dmem_lsu_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt_q;
  logic          we_q, sext_q, err_q, mis_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;

  logic          misaligned;
  logic          timeout;
  logic [3:0]    be_lat;
  logic [31:0]   wdata_lat;
  logic [31:0]   ld_shift;
  logic [31:0]   load_val;

  assign misaligned = (i_size == 2'b11) ||
                      (i_size == 2'b01 && i_addr[0]) ||
                      (i_size == 2'b10 && i_addr[1:0] != 2'b00);

  // Counter saturates at the limit so a grant on the limit cycle still times out in WAIT.
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    be_lat    = 4'b0000;
    wdata_lat = wdata_q;
    case (size_q)
      2'b00: begin
        be_lat    = 4'b0001 << addr_q[1:0];
        wdata_lat = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_lat    = 4'b0011 << addr_q[1:0];
        wdata_lat = {2{wdata_q[15:0]}};
      end
      2'b10: be_lat = 4'b1111;
      default: be_lat = 4'b0000;
    endcase
  end

  always_comb begin
    ld_shift = bus.data_rdata_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{sext_q & ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   load_val = {{16{sext_q & ld_shift[15]}}, ld_shift[15:0]};
      default: load_val = ld_shift;
    endcase
  end

  always_comb begin
    state_nx         = state;
    o_busy           = 1'b0;
    o_done           = 1'b0;
    o_rdata          = '0;
    o_err            = 1'b0;
    o_misaligned     = 1'b0;
    bus.data_req_o   = 1'b0;
    bus.data_we_o    = 1'b0;
    bus.data_be_o    = 4'b0000;
    bus.data_addr_o  = '0;
    bus.data_wdata_o = '0;
    case (state)
      S_IDLE: begin
        if (i_req) state_nx = misaligned ? S_DONE : S_REQ;
      end
      S_REQ: begin
        o_busy           = 1'b1;
        bus.data_req_o   = 1'b1;
        bus.data_we_o    = we_q;
        bus.data_be_o    = be_lat;
        bus.data_addr_o  = {addr_q[31:2], 2'b00};
        bus.data_wdata_o = wdata_lat;
        if (bus.data_gnt_i)  state_nx = S_WAIT;
        else if (timeout)    state_nx = S_DONE;
      end
      S_WAIT: begin
        o_busy = 1'b1;
        if (bus.data_rvalid_i || timeout) state_nx = S_DONE;
      end
      S_DONE: begin
        o_done       = 1'b1;
        o_rdata      = rdata_q;
        o_err        = err_q;
        o_misaligned = mis_q;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (i_req) begin
            we_q    <= i_we;
            size_q  <= i_size;
            sext_q  <= i_sign_ext;
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            mis_q   <= misaligned;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
          end
        end
        S_REQ: begin
          if (!timeout) cnt_q <= cnt_q + CW'(1);
          if (!bus.data_gnt_i && timeout) begin
            err_q   <= 1'b1;
            rdata_q <= we_q ? 32'd0 : ERR_RDATA;
          end
        end
        S_WAIT: begin
          if (!timeout) cnt_q <= cnt_q + CW'(1);
          if (bus.data_rvalid_i) begin
            err_q <= bus.data_err_i;
            if (we_q)                 rdata_q <= '0;
            else if (bus.data_err_i)  rdata_q <= ERR_RDATA;
            else                      rdata_q <= load_val;
          end else if (timeout) begin
            err_q   <= 1'b1;
            rdata_q <= we_q ? 32'd0 : ERR_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed and randomized accesses against an arithmetic reference,
// plus timeout, stale-response and mid-transaction reset scenarios.
module tb_dmem_lsu;
  localparam int TO    = 8;
  localparam int LIMIT = 40;
  localparam logic [31:0] ERRV = 32'hBABECAFE;

  logic        clk, rst_i;
  logic        i_req, i_we, i_sign_ext;
  logic [1:0]  i_size;
  logic [31:0] i_addr, i_wdata;
  logic        o_busy, o_done, o_err, o_misaligned;
  logic [31:0] o_rdata;

  dmem_lsu_if bus ();

  dmem_lsu #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRV)) dut (
    .clk_i(clk), .rst_i(rst_i), .i_req(i_req), .i_we(i_we), .i_size(i_size),
    .i_sign_ext(i_sign_ext), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_err(o_err),
    .o_misaligned(o_misaligned), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gd;
    int          rd;
    logic [31:0] rdata;
    logic        err;
    bit          stale;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  req_n;
    logic        unstable;
  } busv_t;

  typedef struct packed {
    logic        done;
    logic [7:0]  done_cyc;
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    logic [7:0]  busy_n;
  } resv_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic        obs_done, obs_unstable, obs_we, obs_err, obs_mis;
  int          obs_done_cyc, obs_req_n, obs_busy_n;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;

  // Reference: expected bus phase and result from the access rules alone.
  function automatic void model(input vec_t v, output busv_t eb, output resv_t er);
    int off, n;
    longint unsigned full, val;
    eb = '0;
    er = '0;
    er.done = 1'b1;
    off = int'(v.addr % 4);
    n   = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    if (v.size == 2'd3 || (v.addr % n) != 0) begin
      er.mis      = 1'b1;
      er.done_cyc = 8'd1;
      return;
    end
    eb.we = v.we;
    for (int k = 0; k < 4; k++)
      if (k >= off && k < off + n) eb.be[k] = 1'b1;
    eb.addr = v.addr - 32'(off);
    for (int i = 0; i < 4; i++) eb.wdata[8*i +: 8] = v.wdata[8*(i % n) +: 8];
    eb.req_n    = 8'(v.gd + 1);
    er.done_cyc = 8'(v.gd + v.rd + 3);
    er.busy_n   = 8'(v.gd + v.rd + 2);
    er.err      = v.err;
    if (v.we) er.rdata = '0;
    else if (v.err) er.rdata = ERRV;
    else begin
      full = 64'd1 << (8 * n);
      val  = (64'(v.rdata) >> (8 * off)) % full;
      if (v.sext && val >= full / 2) val = val - full;
      er.rdata = val[31:0];
    end
  endfunction

  task automatic clear_bus();
    bus.data_gnt_i    = 1'b0;
    bus.data_rvalid_i = 1'b0;
    bus.data_err_i    = 1'b0;
    bus.data_rdata_i  = '0;
  endtask

  // Core + memory driver: issues one access and records what the DUT did.
  task automatic run_txn(input vec_t v);
    int  c, gnt_c;
    bit  granted;
    obs_done = 0; obs_unstable = 0; obs_we = 0; obs_err = 0; obs_mis = 0;
    obs_done_cyc = -1; obs_req_n = 0; obs_busy_n = 0;
    obs_be = '0; obs_addr = '0; obs_wdata = '0; obs_rdata = '0;
    granted = 0; gnt_c = 0; c = 0;
    @(negedge clk);
    i_req = 1'b1; i_we = v.we; i_size = v.size; i_sign_ext = v.sext;
    i_addr = v.addr; i_wdata = v.wdata;
    while (c < LIMIT && !obs_done) begin
      clear_bus();
      bus.data_rdata_i = $urandom;
      if (bus.data_req_o) begin
        if (obs_req_n == 0) begin
          obs_we = bus.data_we_o; obs_be = bus.data_be_o;
          obs_addr = bus.data_addr_o; obs_wdata = bus.data_wdata_o;
        end else if (obs_we !== bus.data_we_o || obs_be !== bus.data_be_o ||
                     obs_addr !== bus.data_addr_o || obs_wdata !== bus.data_wdata_o)
          obs_unstable = 1'b1;
        obs_req_n++;
        if (v.stale) bus.data_rvalid_i = 1'b1;
        if (!granted && obs_req_n == v.gd + 1) begin
          bus.data_gnt_i = 1'b1;
          granted = 1;
          gnt_c = c;
        end
      end
      if (granted && v.rd >= 0 && c == gnt_c + 1 + v.rd) begin
        bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i  = v.rdata;
        bus.data_err_i    = v.err;
      end
      if (o_busy) obs_busy_n++;
      if (o_done) begin
        obs_done = 1'b1; obs_done_cyc = c;
        obs_rdata = o_rdata; obs_err = o_err; obs_mis = o_misaligned;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    i_req = 1'b0;
    clear_bus();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_sign_ext = 1'b0;
    i_addr = 32'h100; i_wdata = 32'h1234_5678;
    bus.data_gnt_i = 1'b1; bus.data_rvalid_i = 1'b1; bus.data_err_i = 1'b1;
    bus.data_rdata_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({o_busy, o_done} !== 2'b00)
      $display("FAIL reset_ctrl: busy,done=%b required 00", {o_busy, o_done});
    else n_pass++;
    n_checks++;
    if ({o_rdata, o_err, o_misaligned} !== 34'd0)
      $display("FAIL reset_result: rdata=%h err=%b mis=%b required 0", o_rdata, o_err, o_misaligned);
    else n_pass++;
    n_checks++;
    if ({bus.data_req_o, bus.data_we_o, bus.data_be_o, bus.data_addr_o, bus.data_wdata_o} !== 70'd0)
      $display("FAIL reset_bus: req=%b we=%b be=%b addr=%h wdata=%h required all 0",
               bus.data_req_o, bus.data_we_o, bus.data_be_o, bus.data_addr_o, bus.data_wdata_o);
    else n_pass++;
    i_req = 1'b0;
    clear_bus();
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_directed();
    vec_t  tv[7];
    busv_t eb, ob;
    resv_t er, orr;
    tv[0] = '{1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[1] = '{1'b0, 2'b00, 1'b1, 32'h1003, 32'h0, 0, 0, 32'h80FF0000, 1'b0, 1'b0};
    tv[2] = '{1'b0, 2'b01, 1'b0, 32'h1002, 32'h0, 0, 0, 32'h80FF0000, 1'b0, 1'b0};
    tv[3] = '{1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000ABCD, 3, 0, 32'h0, 1'b0, 1'b0};
    tv[4] = '{1'b0, 2'b10, 1'b0, 32'h3001, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0};
    tv[5] = '{1'b0, 2'b01, 1'b1, 32'h0010, 32'h0, 1, 2, 32'h12345678, 1'b1, 1'b0};
    tv[6] = '{1'b0, 2'b11, 1'b0, 32'h4000, 32'h0, 0, 0, 32'h0, 1'b0, 1'b0};
    for (int t = 0; t < 7; t++) begin
      model(tv[t], eb, er);
      run_txn(tv[t]);
      ob  = {obs_we, obs_be, obs_addr, obs_wdata, 8'(obs_req_n), obs_unstable};
      orr = {obs_done, 8'(obs_done_cyc), obs_rdata, obs_err, obs_mis, 8'(obs_busy_n)};
      n_checks++;
      if (ob !== eb) $display("FAIL directed_bus #%0d: got %h required %h", t, ob, eb);
      else n_pass++;
      n_checks++;
      if (orr !== er) $display("FAIL directed_result #%0d: got %h required %h", t, orr, er);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    vec_t  v;
    busv_t eb, ob;
    resv_t er, orr;
    for (int t = 0; t < 40; t++) begin
      v.we    = 1'($urandom_range(0, 1));
      v.size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      v.sext  = 1'($urandom_range(0, 1));
      v.addr  = $urandom;
      if ($urandom_range(0, 2) != 0) v.addr[1:0] = (v.size == 2'b10) ? 2'b00 : {v.addr[1], 1'b0};
      v.wdata = $urandom;
      v.gd    = $urandom_range(0, 3);
      v.rd    = $urandom_range(0, 3);
      v.rdata = $urandom;
      v.err   = ($urandom_range(0, 5) == 0);
      v.stale = ($urandom_range(0, 3) == 0);
      model(v, eb, er);
      run_txn(v);
      ob  = {obs_we, obs_be, obs_addr, obs_wdata, 8'(obs_req_n), obs_unstable};
      orr = {obs_done, 8'(obs_done_cyc), obs_rdata, obs_err, obs_mis, 8'(obs_busy_n)};
      n_checks++;
      if (ob !== eb) $display("FAIL random_bus #%0d: got %h required %h", t, ob, eb);
      else n_pass++;
      n_checks++;
      if (orr !== er) $display("FAIL random_result #%0d: got %h required %h", t, orr, er);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    vec_t  v;
    busv_t eb;
    resv_t er, orr;
    bit    late_done;
    v = '{1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 0, -1, 32'h0, 1'b0, 1'b0};
    run_txn(v);
    n_checks++;
    if (!(obs_done && obs_err && obs_rdata === ERRV && !obs_mis))
      $display("FAIL timeout_wait: done=%b err=%b rdata=%h mis=%b required 1 1 %h 0",
               obs_done, obs_err, obs_rdata, obs_mis, ERRV);
    else n_pass++;
    n_checks++;
    if (obs_done_cyc < TO || obs_done_cyc > TO + 3)
      $display("FAIL timeout_wait_latency: done at cycle %0d required %0d..%0d", obs_done_cyc, TO, TO + 3);
    else n_pass++;
    late_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h1111_2222;
      if (o_done || o_busy) late_done = 1;
    end
    clear_bus();
    n_checks++;
    if (late_done) $display("FAIL timeout_late_rvalid: done/busy seen=1 required 0");
    else n_pass++;

    v = '{1'b0, 2'b00, 1'b0, 32'h6001, 32'h0, 100, 0, 32'h0, 1'b0, 1'b0};
    run_txn(v);
    n_checks++;
    if (!(obs_done && obs_err && obs_rdata === ERRV) || obs_req_n < TO || obs_req_n > TO + 2)
      $display("FAIL timeout_req: done=%b err=%b rdata=%h req_cycles=%0d required 1 1 %h %0d..%0d",
               obs_done, obs_err, obs_rdata, obs_req_n, ERRV, TO, TO + 2);
    else n_pass++;

    // Grant on the last allowed cycle, then rvalid on the next timeout edge.
    v = '{1'b0, 2'b10, 1'b0, 32'h7000, 32'h0, TO, 0, 32'hCAFE_F00D, 1'b0, 1'b0};
    model(v, eb, er);
    run_txn(v);
    orr = {obs_done, 8'(obs_done_cyc), obs_rdata, obs_err, obs_mis, 8'(obs_busy_n)};
    n_checks++;
    if (orr !== er) $display("FAIL timeout_priority: got %h required %h", orr, er);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    vec_t  v;
    busv_t eb, ob;
    resv_t er, orr;
    bit    seen_done;
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b0; i_size = 2'b10; i_sign_ext = 1'b0;
      i_addr = 32'h8000; i_wdata = '0;
      @(negedge clk);
      n_checks++;
      if (bus.data_req_o !== 1'b1) $display("FAIL reset_mid_req_%0d: req=%b required 1", ph, bus.data_req_o);
      else n_pass++;
      if (ph == 1) begin
        bus.data_gnt_i = 1'b1;
        @(negedge clk);
        bus.data_gnt_i = 1'b0;
      end
      rst_i = 1'b1; i_req = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      n_checks++;
      if ({bus.data_req_o, o_busy, bus.data_be_o} !== 6'd0)
        $display("FAIL reset_mid_drop_%0d: req=%b busy=%b be=%b required 0", ph,
                 bus.data_req_o, o_busy, bus.data_be_o);
      else n_pass++;
      seen_done = 0;
      for (int k = 0; k < 4; k++) begin
        bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'h5555_AAAA;
        if (o_done) seen_done = 1;
        @(negedge clk);
      end
      if (o_done) seen_done = 1;
      clear_bus();
      n_checks++;
      if (seen_done) $display("FAIL reset_mid_no_done_%0d: done seen=1 required 0", ph);
      else n_pass++;
    end
    v = '{1'b0, 2'b10, 1'b0, 32'h9008, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0};
    model(v, eb, er);
    run_txn(v);
    ob  = {obs_we, obs_be, obs_addr, obs_wdata, 8'(obs_req_n), obs_unstable};
    orr = {obs_done, 8'(obs_done_cyc), obs_rdata, obs_err, obs_mis, 8'(obs_busy_n)};
    n_checks++;
    if (ob !== eb || orr !== er)
      $display("FAIL reset_mid_recover: bus %h res %h required bus %h res %h", ob, orr, eb, er);
    else n_pass++;
  endtask

  initial begin
    rst_i = 1'b1; i_req = 1'b0; i_we = 1'b0; i_size = 2'b00; i_sign_ext = 1'b0;
    i_addr = '0; i_wdata = '0;
    clear_bus();
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max cycles from bus request to response before a timeout error.
REQ-002 Parameter ERR_RDATA, default 32'hBABECAFE, SHALL set the value returned on o_rdata for any errored or timed-out load.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 i_req  input  1  core access request; core holds i_req and operands stable until o_done.
REQ-006 i_we  input  1  1 = store, 0 = load.
REQ-007 i_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 i_sign_ext  input  1  load result sign-extended when 1, zero-extended when 0.
REQ-009 i_addr  input  32  byte address.
REQ-010 i_wdata  input  32  store data, right-aligned.
REQ-011 o_busy  output  1  high in REQ or WAIT state.
REQ-012 o_done  output  1  one-cycle completion pulse.
REQ-013 o_rdata  output  32  aligned, extended load data, valid with o_done.
REQ-014 o_err  output  1  bus error or timeout, valid with o_done.
REQ-015 o_misaligned  output  1  alignment fault, valid with o_done.
REQ-016 data_req_o, data_we_o  output  1 each  bus request and write enable.
REQ-017 data_be_o  output  4  byte enables; data_addr_o  output  32; data_wdata_o  output  32.
REQ-018 data_gnt_i, data_rvalid_i, data_err_i  input  1 each; data_rdata_i  input  32.

Function
REQ-019 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-020 IDLE: on i_req, latch we/size/sign_ext/addr/wdata; aligned -> REQ; misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 11) -> DONE with o_misaligned=1 and no bus request.
REQ-021 REQ: data_req_o=1; data_we_o, data_be_o, data_addr_o, data_wdata_o SHALL be driven from latched values and held stable until data_gnt_i; on data_gnt_i -> WAIT.
REQ-022 WAIT: data_req_o=0; on data_rvalid_i, capture data_rdata_i and data_err_i -> DONE.
REQ-023 DONE: o_done=1 for exactly one cycle, then -> IDLE; new i_req is accepted in IDLE only.
REQ-024 data_addr_o SHALL be {addr[31:2],2'b00}.
REQ-025 data_be_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; 4'b0000 outside REQ.
REQ-026 data_wdata_o: byte replicated to all four lanes, half replicated to both halves, word passed through.
REQ-027 Load data SHALL be shifted right by addr[1:0]*8, masked to size, sign- or zero-extended per i_sign_ext; stores SHALL return o_rdata=0.
REQ-028 Errored (data_err_i) or timed-out loads SHALL return o_rdata=ERR_RDATA with o_err=1.
REQ-029 A timeout counter SHALL clear on entry to REQ and increment each cycle in REQ/WAIT; at TIMEOUT_CYCLES -> DONE with o_err=1; width = $clog2(TIMEOUT_CYCLES+1).
REQ-030 data_rvalid_i in IDLE, REQ or DONE SHALL be ignored (stale/late responses dropped).
REQ-031 Minimum latency: i_req at cycle 0, data_req_o at 1, gnt at 1, rvalid at 2, o_done at 3.
REQ-032 Grant and timeout in the same cycle: grant wins (-> WAIT); rvalid and timeout in the same cycle: rvalid wins.

Reset
REQ-033 While rst_i is high at a clock edge: state -> IDLE, counter = 0, all outputs 0 (o_rdata=0, data_be_o=0) from the next cycle.
REQ-034 Reset mid-transaction SHALL drop data_req_o next cycle, produce no o_done, and ignore any later rvalid.

Verification
REQ-035 LW addr 0x1004, gnt immediate, rvalid next cycle, rdata 0xDEADBEEF -> data_be_o=1111, data_addr_o=0x1004, o_done at cycle 3, o_rdata=0xDEADBEEF.
REQ-036 LB signed addr 0x1003, rdata 0x80FF_0000 -> be=1000, o_rdata=0xFFFFFF80; LHU addr 0x1002 same rdata -> be=1100, o_rdata=0x000080FF.
REQ-037 SH addr 0x2002, wdata 0x0000ABCD, gnt delayed 3 cycles -> data_req_o, be=1100, wdata=0xABCDABCD held stable 4 cycles; o_done, o_err=0.
REQ-038 LW addr 0x3001 -> no data_req_o, o_done one cycle later with o_misaligned=1.
REQ-039 TIMEOUT_CYCLES=8, grant but no rvalid -> o_done with o_err=1, o_rdata=0xBABECAFE; late rvalid afterwards ignored.
REQ-040 rst_i asserted in WAIT -> data_req_o=0, no o_done, subsequent rvalid ignored, next LW completes normally.
